mdu_sequencer: RTL

- Iterative RV32M/RV64M multiply/divide unit with its own operation decode.
- Sits beside the ALU and its control in the single-cycle datapath.
- Decodes the same {funct7, ALU_Op, funct3} selector the ALU control uses; claims only M-extension R-type ops.
- Runs a multi-cycle shift-add or restoring-divide sequence, stalling the core until the result is ready.

---
 rtl/mdu_sequencer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// ----------------------------------------------------------------------------
// mdu_sequencer
//   Iterative RV32M/RV64M multiply/divide unit. It decodes the same
//   {funct7, ALU_Op, funct3} selector as the ALU control and claims only the
//   M-extension R-type ops. Multiplies run a shift-add sequence. Divides run a
//   restoring sequence. The core is stalled until the result is ready.
//
// Ports
//   clk        in   core clock, rising edge
//   reset      in   asynchronous active-low reset
//   start_i    in   instruction valid this cycle
//   funct7_i   in   instruction funct7
//   ALU_Op_i   in   op class from the main control
//   funct3_i   in   instruction funct3 (selects the M op)
//   rs1_i      in   operand A
//   rs2_i      in   operand B
//   kill_i     in   abort the current op (flush)
//   is_mdu_o   out  combinational: selector decodes to an M op
//   stall_o    out  combinational: hold PC/instruction
//   busy_o     out  registered: sequence in progress
//   done_o     out  registered: 1-cycle pulse, result valid
//   result_o   out  registered result, held until the next accept
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an accepted M op
// MUL    | one shift-add step per cycle on the 2*XLEN product
// DIV    | one restoring-divide step per cycle
// FIX    | sign correction and result select, register result_o
// DONE   | done_o pulse; back to IDLE next cycle
// ----------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int unsigned         XLEN         = 32,
  parameter int unsigned         ALU_OP_W     = 3,
  parameter logic [ALU_OP_W-1:0] R_TYPE_OP    = '0,
  parameter bit                  FAST_SPECIAL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [6:0]          funct7_i,
  input  logic [ALU_OP_W-1:0] ALU_Op_i,
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  input  logic                kill_i,
  output logic                is_mdu_o,
  output logic                stall_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [XLEN-1:0]     result_o
);

  localparam int unsigned    CW      = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // MUL: {hi,lo} is the running product, opnd is the multiplicand magnitude.
  // DIV: hi is the partial remainder, lo shifts the dividend out and the
  //      quotient in, opnd is the divisor magnitude.
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic            sel_q, sel_d;     // MUL: high half; DIV: remainder
  logic            neg_q, neg_d;     // negate product / quotient
  logic            rneg_q, rneg_d;   // negate remainder (dividend sign)
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // ---------------------------------------------------------------- decode
  logic            accept;
  logic            f_div, f_sa, f_sb;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast_hit;
  logic [XLEN-1:0] fast_res;

  assign is_mdu_o = (ALU_Op_i == R_TYPE_OP) && (funct7_i == 7'b0000001);
  assign stall_o  = start_i && is_mdu_o && !done_q && !kill_i;
  assign accept   = (state_q == S_IDLE) && start_i && is_mdu_o && !kill_i;

  assign f_div = funct3_i[2];
  // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH treat rs2 as signed.
  // MUL's low half is the same either way, so it rides the signed path.
  assign f_sa  = f_div ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
  assign f_sb  = f_div ? !funct3_i[0] : !funct3_i[1];
  assign a_neg = f_sa && rs1_i[XLEN-1];
  assign b_neg = f_sb && rs2_i[XLEN-1];
  assign a_mag = a_neg ? -rs1_i : rs1_i;
  assign b_mag = b_neg ? -rs2_i : rs2_i;

  assign div_zero = f_div && (rs2_i == '0);
  assign div_ovf  = f_div && !funct3_i[0] && (rs1_i == MIN_NEG) && (&rs2_i);
  assign fast_hit = FAST_SPECIAL && (div_zero || div_ovf);

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = funct3_i[1] ? rs1_i : '1;
    end else begin
      fast_res = funct3_i[1] ? '0 : MIN_NEG;
    end
  end

  // ------------------------------------------------------------ datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic            div_fits;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] fix_res;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_fits  = !div_trial[XLEN];
  assign prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    fix_res = '0;
    if (!is_div_q) begin
      fix_res = sel_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end else if (sel_q) begin
      fix_res = rneg_q ? -hi_q : hi_q;
    end else begin
      fix_res = neg_q ? -lo_q : lo_q;
    end
  end

  // --------------------------------------------------------- next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d = f_div;
          sel_d    = f_div ? funct3_i[1] : (funct3_i[1:0] != 2'b00);
          // A zero divisor yields all-ones from the restoring loop; keep it
          // un-negated so the signed DIV result is still all ones.
          neg_d    = (a_neg ^ b_neg) && !div_zero;
          rneg_d   = a_neg;
          if (fast_hit) begin
            state_d  = S_DONE;
            result_d = fast_res;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else begin
            state_d = f_div ? S_DIV : S_MUL;
            cnt_d   = CW'(XLEN);
            busy_d  = 1'b1;
            hi_d    = '0;
            lo_d    = f_div ? a_mag : b_mag;
            opnd_d  = f_div ? b_mag : a_mag;
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_sum[XLEN:1];
        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        hi_d  = div_fits ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], div_fits};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Flush wins over everything, including a same-cycle accept.
    if (kill_i) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sel_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sel_q    <= sel_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
